// File: rtl/reducer_pkg.sv
// Shared definitions for the reducer receive path.
// Pair layout matches the mapper transmitter word order.
package reducer_pkg;

    typedef enum logic [2:0] {
        RECV   = 3'd0,
        MATCH  = 3'd1,
        UPDATE = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int PAIR_W = 128;
    localparam int KEY_W  = 96;
    localparam int CNT_W  = 32;
    localparam int WORD_W = 32;

    localparam logic [1:0] W_KEY0 = 2'd0;
    localparam logic [1:0] W_KEY1 = 2'd1;
    localparam logic [1:0] W_KEY2 = 2'd2;
    localparam logic [1:0] W_CNT  = 2'd3;

    function automatic logic [WORD_W-1:0] pair_word(
        input logic [KEY_W-1:0] key,
        input logic [CNT_W-1:0] cnt,
        input logic [1:0]       sel
    );
        logic [WORD_W-1:0] w;
        case (sel)
            W_KEY0:  w = key[31:0];
            W_KEY1:  w = key[63:32];
            W_KEY2:  w = key[95:64];
            default: w = cnt;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/reducer_noc_key_table.sv
// Key/count storage with parallel match and saturating merge.
// Lowest matching index wins; misses append at entry_cnt.
module key_table
    import reducer_pkg::*;
#(
    parameter int KEY_NUM = 10,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [KEY_W-1:0] key,
    input  logic [CNT_W-1:0] cnt,
    input  logic             match_en,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_key,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [IDX_W-1:0] entry_cnt,
    output logic             drop
);

    logic [KEY_W-1:0] keys [KEY_NUM];
    logic [CNT_W-1:0] cnts [KEY_NUM];
    logic [KEY_NUM-1:0] valid;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             m_hit;
    logic [IDX_W-1:0] m_idx;
    logic             full;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] sat;

    // Scan high to low so the lowest match overwrites last.
    always_comb begin
        m_hit = 1'b0;
        m_idx = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (valid[i] && keys[i] == key) begin
                m_hit = 1'b1;
                m_idx = IDX_W'(i);
            end
        end
    end

    assign full   = (entry_cnt == IDX_W'(KEY_NUM));
    assign drop   = upd_en && !hit && full;
    assign sum    = {1'b0, cnts[hit_idx]} + {1'b0, cnt};
    assign sat    = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    assign rd_key = keys[rd_idx];
    assign rd_cnt = cnts[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < KEY_NUM; i++) begin
                keys[i] <= '0;
                cnts[i] <= '0;
            end
            valid     <= '0;
            entry_cnt <= '0;
            hit       <= 1'b0;
            hit_idx   <= '0;
        end else if (clr) begin
            valid     <= '0;
            entry_cnt <= '0;
            hit       <= 1'b0;
        end else begin
            if (match_en) begin
                hit     <= m_hit;
                hit_idx <= m_idx;
            end
            if (upd_en) begin
                if (hit) begin
                    cnts[hit_idx] <= sat;
                end else if (!full) begin
                    keys[entry_cnt]  <= key;
                    cnts[entry_cnt]  <= cnt;
                    valid[entry_cnt] <= 1'b1;
                    entry_cnt        <= entry_cnt + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/reducer_noc.sv
// Reducer receive side: flit reassembly, merge control, flush serialiser.
// The key table itself lives in key_table.
module reducer_noc
    import reducer_pkg::*;
#(
    parameter int KEY_NUM = 10,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_in_ready,
    output logic              rx_ready,
    input  logic              flush,
    input  logic              clear,
    input  logic              result_ready,
    output logic [WORD_W-1:0] data_out,
    output logic              data_out_ready,
    output logic              done,
    output logic              overflow
);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       word_cnt;
    logic [KEY_W-1:0] key_buf;
    logic [CNT_W-1:0] cnt_buf;
    logic             flush_pend;
    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       rd_word;
    logic [KEY_W-1:0] rd_key;
    logic [CNT_W-1:0] rd_cnt;
    logic [IDX_W-1:0] entry_cnt;
    logic             drop;
    logic             accept;
    logic             emit;
    logic             last;
    logic             tbl_clr;

    assign rx_ready = (state == RECV);
    assign done     = (state == DONE);
    assign accept   = data_in_ready && rx_ready;
    assign emit     = (state == FLUSH) && result_ready && (entry_cnt != '0);
    assign last     = (rd_idx == entry_cnt - IDX_W'(1)) && (rd_word == W_CNT);
    assign tbl_clr  = (state == DONE) && clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RECV;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = RECV;
        case (state)
            RECV: begin
                state_nxt = RECV;
                if (accept && word_cnt == 2'd3)
                    state_nxt = MATCH;
                else if (!accept && word_cnt == 2'd0 && (flush || flush_pend))
                    state_nxt = FLUSH;
            end
            MATCH:  state_nxt = UPDATE;
            UPDATE: state_nxt = (flush || flush_pend) ? FLUSH : RECV;
            FLUSH: begin
                state_nxt = FLUSH;
                if (entry_cnt == '0 || (emit && last))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = clear ? RECV : DONE;
            default: state_nxt = RECV;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt       <= '0;
            key_buf        <= '0;
            cnt_buf        <= '0;
            flush_pend     <= 1'b0;
            overflow       <= 1'b0;
            rd_idx         <= '0;
            rd_word        <= '0;
            data_out       <= '0;
            data_out_ready <= 1'b0;
        end else begin
            if (accept) begin
                word_cnt <= word_cnt + 2'd1;
                case (word_cnt)
                    W_KEY0:  key_buf[31:0]  <= data_in;
                    W_KEY1:  key_buf[63:32] <= data_in;
                    W_KEY2:  key_buf[95:64] <= data_in;
                    default: cnt_buf        <= data_in;
                endcase
            end
            // Flush requests seen mid-pair wait for the pair to land.
            if (state_nxt == FLUSH)
                flush_pend <= 1'b0;
            else if (flush && (state == RECV || state == MATCH || state == UPDATE))
                flush_pend <= 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (tbl_clr)
                overflow <= 1'b0;
            if (state != FLUSH) begin
                rd_idx  <= '0;
                rd_word <= '0;
            end else if (emit) begin
                rd_word <= rd_word + 2'd1;
                if (rd_word == W_CNT)
                    rd_idx <= rd_idx + IDX_W'(1);
            end
            if (emit) begin
                data_out       <= pair_word(rd_key, rd_cnt, rd_word);
                data_out_ready <= 1'b1;
            end else begin
                data_out       <= '0;
                data_out_ready <= 1'b0;
            end
        end
    end

    key_table #(
        .KEY_NUM(KEY_NUM),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .clr      (tbl_clr),
        .key      (key_buf),
        .cnt      (cnt_buf),
        .match_en (state == MATCH),
        .upd_en   (state == UPDATE),
        .rd_idx   (rd_idx),
        .rd_key   (rd_key),
        .rd_cnt   (rd_cnt),
        .entry_cnt(entry_cnt),
        .drop     (drop)
    );

endmodule

// File: tb/tb_reducer_noc.sv
// Directed bench for reducer_noc with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_reducer_noc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_in = '0;
    logic        data_in_ready = 1'b0;
    logic        rx_ready;
    logic        flush = 1'b0;
    logic        clear = 1'b0;
    logic        result_ready = 1'b0;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        done;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] got [$];

    always #5 clk = ~clk;

    reducer_noc dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_ready (data_in_ready),
        .rx_ready      (rx_ready),
        .flush         (flush),
        .clear         (clear),
        .result_ready  (result_ready),
        .data_out      (data_out),
        .data_out_ready(data_out_ready),
        .done          (done),
        .overflow      (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] mk_key(input int i);
        return {32'hA000_0000 + i, 32'hB000_0000 + i, 32'hC000_0000 + i};
    endfunction

    task automatic wait_rx();
        int n = 0;
        while (!rx_ready && n < 20) begin
            step();
            n++;
        end
        if (!rx_ready) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input logic f);
        wait_rx();
        data_in = w;
        data_in_ready = 1'b1;
        flush = f;
        step();
        data_in_ready = 1'b0;
        flush = 1'b0;
    endtask

    task automatic send_pair(input logic [95:0] k, input logic [31:0] c);
        send_word(k[31:0], 1'b0);
        send_word(k[63:32], 1'b0);
        send_word(k[95:64], 1'b0);
        send_word(c, 1'b0);
    endtask

    task automatic do_flush();
        wait_rx();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic collect(input bit toggle);
        int n;
        got.delete();
        for (n = 0; n < 300; n++) begin
            result_ready = toggle ? (n % 2 == 0) : 1'b1;
            step();
            if (toggle) chk("dor_follows_rr", 32'(data_out_ready), 32'(result_ready));
            if (data_out_ready) got.push_back(data_out);
            if (done) break;
        end
        result_ready = 1'b0;
        if (!done) chk("collect_timeout", 32'(done), 32'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("done_after_clear", 32'(done), 32'd0);
    endtask

    initial begin
        logic [95:0] cat;
        logic [95:0] k;
        cat = 96'h636174;

        // Reset state
        #12;
        chk("rst_dor", 32'(data_out_ready), 32'd0);
        chk("rst_dout", data_out, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b1;
        step();
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);

        // Single pair
        send_pair(cat, 32'd1);
        chk("rx_low_match", 32'(rx_ready), 32'd0);
        step();
        chk("rx_low_update", 32'(rx_ready), 32'd0);
        step();
        chk("rx_back_recv", 32'(rx_ready), 32'd1);
        do_flush();
        collect(1'b0);
        chk("t1_nwords", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            chk("t1_w0", got[0], 32'h0063_6174);
            chk("t1_w1", got[1], 32'd0);
            chk("t1_w2", got[2], 32'd0);
            chk("t1_w3", got[3], 32'd1);
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_rx_in_done", 32'(rx_ready), 32'd0);
        do_clear();

        // Same key merged
        k = mk_key(2);
        send_pair(k, 32'd1);
        send_pair(k, 32'd2);
        send_pair(k, 32'd5);
        do_flush();
        collect(1'b0);
        chk("t2_nwords", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            chk("t2_w0", got[0], 32'hC000_0002);
            chk("t2_w2", got[2], 32'hA000_0002);
            chk("t2_cnt", got[3], 32'd8);
        end
        do_clear();

        // Table overflow
        for (int i = 0; i < 10; i++) send_pair(mk_key(i), 32'(i + 1));
        wait_rx();
        chk("t3_ovf_pre", 32'(overflow), 32'd0);
        send_pair(mk_key(10), 32'd11);
        wait_rx();
        chk("t3_ovf_set", 32'(overflow), 32'd1);
        do_flush();
        collect(1'b0);
        chk("t3_nwords", 32'(got.size()), 32'd40);
        if (got.size() == 40) begin
            chk("t3_e0_w0", got[0], 32'hC000_0000);
            chk("t3_e0_cnt", got[3], 32'd1);
            chk("t3_e9_w0", got[36], 32'hC000_0009);
            chk("t3_e9_w2", got[38], 32'hA000_0009);
            chk("t3_e9_cnt", got[39], 32'd10);
        end
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);
        do_clear();
        chk("t3_ovf_cleared", 32'(overflow), 32'd0);

        // Saturation, then flush raised mid-pair
        k = mk_key(20);
        send_pair(k, 32'hFFFF_FFF0);
        send_pair(k, 32'h20);
        k = mk_key(21);
        send_word(k[31:0], 1'b0);
        send_word(k[63:32], 1'b0);
        send_word(k[95:64], 1'b1);
        send_word(32'd7, 1'b0);
        chk("t5_rx_match", 32'(rx_ready), 32'd0);
        step();
        step();
        chk("t5_in_flush_rx", 32'(rx_ready), 32'd0);
        chk("t5_in_flush_done", 32'(done), 32'd0);
        collect(1'b1);
        chk("t5_nwords", 32'(got.size()), 32'd8);
        if (got.size() == 8) begin
            chk("t5_e0_w0", got[0], 32'hC000_0014);
            chk("t5_sat_cnt", got[3], 32'hFFFF_FFFF);
            chk("t5_e1_w0", got[4], 32'hC000_0015);
            chk("t5_e1_w1", got[5], 32'hB000_0015);
            chk("t5_e1_cnt", got[7], 32'd7);
        end
        do_clear();

        // Reset in the middle of a flush
        send_pair(mk_key(0), 32'd3);
        send_pair(mk_key(1), 32'd4);
        do_flush();
        result_ready = 1'b1;
        step();
        step();
        chk("t6_pre_dor", 32'(data_out_ready), 32'd1);
        chk("t6_pre_w1", data_out, 32'hB000_0000);
        result_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("t6_rst_dor", 32'(data_out_ready), 32'd0);
        chk("t6_rst_dout", data_out, 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        step();
        rst = 1'b1;
        step();
        do_flush();
        collect(1'b0);
        chk("t6_empty_words", 32'(got.size()), 32'd0);
        chk("t6_empty_done", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
